program_sequencer_stack: RTL and testbench
==========================================

PROGRAM_SEQUENCER_STACK -- requirements
Module: program_sequencer_stack

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning program-memory address width in bits (legal range 4..16).
REQ-002 The block SHALL have parameter STACK_DEPTH, default 4, meaning the number of return-address entries (legal range 1..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port sync_reset, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port stall, input, 1 bit: hold the current fetch address.
REQ-006 The block SHALL have port jump, input, 1 bit: unconditional jump.
REQ-007 The block SHALL have port conditional_jump, input, 1 bit: jump unless dont_jmp is high.
REQ-008 The block SHALL have port dont_jmp, input, 1 bit: condition flag from the ALU zero flag.
REQ-009 The block SHALL have port call, input, 1 bit: subroutine call.
REQ-010 The block SHALL have port ret, input, 1 bit: subroutine return.
REQ-011 The block SHALL have port jump_address, input, ADDR_W bits: target for jump, conditional_jump and call.
REQ-012 The block SHALL have port pm_addr, output, ADDR_W bits: combinational program-memory address.
REQ-013 The block SHALL have port pc, output, ADDR_W bits: registered copy of the last pm_addr.
REQ-014 The block SHALL have port sp, output, $clog2(STACK_DEPTH+1) bits: count of occupied stack entries.
REQ-015 The block SHALL have port stack_overflow, output, 1 bit: sticky flag, push attempted while full.
REQ-016 The block SHALL have port stack_underflow, output, 1 bit: sticky flag, pop attempted while empty.

Function
REQ-017 pm_addr SHALL be selected by fixed priority: sync_reset -> 0; stall -> pc; ret -> top of stack; call -> jump_address; jump -> jump_address; conditional_jump & !dont_jmp -> jump_address; otherwise pc+1.
REQ-018 pc+1 SHALL wrap modulo 2^ADDR_W, so all-ones increments to 0.
REQ-019 pc SHALL load pm_addr on every rising clk edge, giving one cycle of latency from pm_addr to pc.
REQ-020 A call that is not stalled and not overridden by ret SHALL push pc+1 (wrapped) and increment sp in the same edge.
REQ-021 A ret that is not stalled SHALL pop the top entry and decrement sp in the same edge.
REQ-022 When call and ret are asserted together, ret SHALL win, and call SHALL have no effect on the stack or on pm_addr.
REQ-023 A call with sp == STACK_DEPTH SHALL still jump to jump_address, SHALL NOT modify the stack or sp, and SHALL set stack_overflow.
REQ-024 A ret with sp == 0 SHALL drive pm_addr = pc+1, SHALL leave sp at 0, and SHALL set stack_underflow.
REQ-025 stall SHALL freeze pc, sp, the stack contents and both flags, and SHALL override call, ret and all jumps.
REQ-026 stack_overflow and stack_underflow SHALL stay set until sync_reset.
REQ-027 The stack SHALL behave as a LIFO, so nested calls up to STACK_DEPTH return in reverse order.

Reset
REQ-028 While sync_reset is high: pm_addr = 0 combinationally; on the next edge pc = 0, sp = 0, and both flags clear.
REQ-029 sync_reset SHALL take priority over stall, call and ret mid-operation, and no push or pop SHALL occur in a reset cycle.
REQ-030 Stack entry contents SHALL NOT require reset; entries are unreadable while sp == 0 (REQ-024).

Structure
REQ-031 A shared package seq_pkg SHALL hold the default ADDR_W and STACK_DEPTH constants and the next-address-select enumeration {SEL_ZERO, SEL_HOLD, SEL_RET, SEL_TARGET, SEL_INC}.
REQ-032 The stack SHALL be a separate sub-module return_stack with push, pop, data in, top-of-stack, count, full and empty signals.
REQ-033 The priority selection SHALL live in program_sequencer_stack, with no further sub-modules.

Verification
REQ-034 Reset then 5 idle cycles -> pm_addr sequence 0,1,2,3,4,5; pc lags by one cycle; sp = 0; flags = 0.
REQ-035 At pc = 0x10, call with jump_address = 0x40, then ret at pc = 0x42 -> pm_addr = 0x40, then 0x41, 0x42, 0x11; sp goes 1 then 0.
REQ-036 STACK_DEPTH = 4: five nested calls -> fifth call jumps, sp stays 4, overflow = 1; four rets return the four stored addresses in LIFO order; a fifth ret -> pm_addr = pc+1, underflow = 1.
REQ-037 conditional_jump to 0x20 with dont_jmp = 1 -> pm_addr = pc+1; same stimulus with dont_jmp = 0 -> pm_addr = 0x20. ADDR_W = 8 at pc = 0xFF with no jump -> pm_addr = 0x00.
REQ-038 call and ret together with sp = 1 -> pop only, sp = 0; stall held 3 cycles during a call -> pc, sp unchanged; the call executes the cycle stall drops.
REQ-039 sync_reset asserted while sp = 3 with overflow set -> next edge pc = 0, sp = 0, overflow = 0, underflow = 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared constants and next-address select encoding for the program sequencer.
package seq_pkg;

  localparam int DEFAULT_ADDR_W      = 8;
  localparam int DEFAULT_STACK_DEPTH = 4;

  typedef enum logic [2:0] {
    SEL_ZERO   = 3'd0,
    SEL_HOLD   = 3'd1,
    SEL_RET    = 3'd2,
    SEL_TARGET = 3'd3,
    SEL_INC    = 3'd4
  } next_sel_e;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; push while full and pop while empty are ignored here,
// so the caller only has to raise the sticky error flags.
module return_stack
  import seq_pkg::*;
#(
  parameter int DATA_W = DEFAULT_ADDR_W,
  parameter int DEPTH  = DEFAULT_STACK_DEPTH
) (
  input  logic                         clk,
  input  logic                         sync_reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            din,
  output logic [DATA_W-1:0]            tos,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [CNT_W-1:0]  count_r;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic              full_s;
  logic              empty_s;
  logic              do_push_s;
  logic              do_pop_s;

  // Occupancy flags, slot indices and guarded push/pop strobes.
  always_comb begin
    full_s    = (count_r == CNT_W'(DEPTH));
    empty_s   = (count_r == {CNT_W{1'b0}});
    wr_idx_s  = IDX_W'(count_r);
    rd_idx_s  = IDX_W'(count_r - CNT_W'(1'b1));
    do_push_s = push & ~full_s & ~pop;
    do_pop_s  = pop & ~empty_s;
    if (empty_s) begin
      tos = {DATA_W{1'b0}};
    end else begin
      tos = mem_r[rd_idx_s];
    end
  end

  // Occupancy counter.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (do_push_s) begin
      count_r <= count_r + CNT_W'(1'b1);
    end else if (do_pop_s) begin
      count_r <= count_r - CNT_W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  // Entry storage; contents are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push_s && !sync_reset) begin
      mem_r[wr_idx_s] <= din;
    end
  end

  assign count = count_r;
  assign full  = full_s;
  assign empty = empty_s;

endmodule

// File: rtl/program_sequencer_stack.sv
// Program-memory address sequencer with fixed-priority next-address select
// and a return-address stack for call/ret.
module program_sequencer_stack
  import seq_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
  input  logic                               clk,
  input  logic                               sync_reset,
  input  logic                               stall,
  input  logic                               jump,
  input  logic                               conditional_jump,
  input  logic                               dont_jmp,
  input  logic                               call,
  input  logic                               ret,
  input  logic [ADDR_W-1:0]                  jump_address,
  output logic [ADDR_W-1:0]                  pm_addr,
  output logic [ADDR_W-1:0]                  pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);

  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_inc_s;
  logic [ADDR_W-1:0] pm_addr_s;
  logic [ADDR_W-1:0] tos_s;
  logic [SP_W-1:0]   count_s;
  logic              full_s;
  logic              empty_s;
  logic              active_s;
  logic              push_s;
  logic              pop_s;
  logic              ovf_set_s;
  logic              unf_set_s;
  logic              overflow_r;
  logic              underflow_r;
  next_sel_e         sel_s;

  return_stack #(
    .DATA_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk        (clk),
    .sync_reset (sync_reset),
    .push       (push_s),
    .pop        (pop_s),
    .din        (pc_inc_s),
    .tos        (tos_s),
    .count      (count_s),
    .full       (full_s),
    .empty      (empty_s)
  );

  // Priority select and stack/flag strobes; ret always masks call.
  always_comb begin
    pc_inc_s  = pc_r + ADDR_W'(1'b1);
    active_s  = ~sync_reset & ~stall;
    push_s    = active_s & ~ret & call & ~full_s;
    ovf_set_s = active_s & ~ret & call & full_s;
    pop_s     = active_s & ret & ~empty_s;
    unf_set_s = active_s & ret & empty_s;
    sel_s     = SEL_INC;
    if (sync_reset) begin
      sel_s = SEL_ZERO;
    end else if (stall) begin
      sel_s = SEL_HOLD;
    end else if (ret) begin
      if (empty_s) begin
        sel_s = SEL_INC;
      end else begin
        sel_s = SEL_RET;
      end
    end else if (call || jump || (conditional_jump && !dont_jmp)) begin
      sel_s = SEL_TARGET;
    end else begin
      sel_s = SEL_INC;
    end
  end

  // Next-address mux.
  always_comb begin
    case (sel_s)
      SEL_ZERO:   pm_addr_s = {ADDR_W{1'b0}};
      SEL_HOLD:   pm_addr_s = pc_r;
      SEL_RET:    pm_addr_s = tos_s;
      SEL_TARGET: pm_addr_s = jump_address;
      SEL_INC:    pm_addr_s = pc_inc_s;
      default:    pm_addr_s = pc_inc_s;
    endcase
  end

  // Program counter and sticky stack error flags.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      pc_r        <= {ADDR_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      pc_r        <= pm_addr_s;
      overflow_r  <= overflow_r | ovf_set_s;
      underflow_r <= underflow_r | unf_set_s;
    end
  end

  assign pm_addr         = pm_addr_s;
  assign pc              = pc_r;
  assign sp              = count_s;
  assign stack_overflow  = overflow_r;
  assign stack_underflow = underflow_r;

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Directed scoreboard bench: the driver queues hand-computed expectations each
// cycle; an independent monitor samples the DUT and compares.
module tb_program_sequencer_stack;

  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_RST   = 7'b1000000;
  localparam logic [6:0] C_STALL = 7'b0100000;
  localparam logic [6:0] C_RET   = 7'b0010000;
  localparam logic [6:0] C_CALL  = 7'b0001000;
  localparam logic [6:0] C_JMP   = 7'b0000100;
  localparam logic [6:0] C_CJ    = 7'b0000010;
  localparam logic [6:0] C_DJ    = 7'b0000001;

  typedef struct packed {
    logic [7:0] pm;
    logic [2:0] sp;
    logic       ov;
    logic       un;
  } exp_t;

  logic       clk;
  logic       sync_reset, stall, jump, conditional_jump, dont_jmp, call, ret;
  logic [7:0] jump_address;
  logic [7:0] pm_addr, pc;
  logic [2:0] sp;
  logic       stack_overflow, stack_underflow;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  program_sequencer_stack #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
    .clk              (clk),
    .sync_reset       (sync_reset),
    .stall            (stall),
    .jump             (jump),
    .conditional_jump (conditional_jump),
    .dont_jmp         (dont_jmp),
    .call             (call),
    .ret              (ret),
    .jump_address     (jump_address),
    .pm_addr          (pm_addr),
    .pc               (pc),
    .sp               (sp),
    .stack_overflow   (stack_overflow),
    .stack_underflow  (stack_underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus plus the expectation: pm_addr this cycle, and
  // pc/sp/flags after the coming edge (pc always takes pm_addr).
  task automatic cyc(input logic [6:0] ctl, input logic [7:0] ja,
                     input logic [7:0] e_pm, input logic [2:0] e_sp,
                     input logic e_ov, input logic e_un);
    exp_t e;
    @(negedge clk);
    sync_reset       = ctl[6];
    stall            = ctl[5];
    ret              = ctl[4];
    call             = ctl[3];
    jump             = ctl[2];
    conditional_jump = ctl[1];
    dont_jmp         = ctl[0];
    jump_address     = ja;
    e.pm = e_pm; e.sp = e_sp; e.ov = e_ov; e.un = e_un;
    q.push_back(e);
  endtask

  // Monitor: sample pm_addr mid-low-phase, state just after the edge.
  initial begin
    exp_t       e;
    logic [7:0] pm_smp;
    forever begin
      @(negedge clk);
      #2;
      pm_smp = pm_addr;
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("pm_addr", int'(pm_smp), int'(e.pm));
        check("pc", int'(pc), int'(e.pm));
        check("sp", int'(sp), int'(e.sp));
        check("overflow", int'(stack_overflow), int'(e.ov));
        check("underflow", int'(stack_underflow), int'(e.un));
      end
    end
  end

  initial begin
    sync_reset = 1'b1; stall = 1'b0; jump = 1'b0; conditional_jump = 1'b0;
    dont_jmp = 1'b0; call = 1'b0; ret = 1'b0; jump_address = 8'h00;

    // Reset then idle count-up.
    cyc(C_RST, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    cyc(C_RST, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) cyc(C_IDLE, 8'h00, 8'(i), 3'd0, 1'b0, 1'b0);

    // Single call/return.
    cyc(C_JMP,  8'h10, 8'h10, 3'd0, 1'b0, 1'b0);
    cyc(C_CALL, 8'h40, 8'h40, 3'd1, 1'b0, 1'b0);
    cyc(C_IDLE, 8'h00, 8'h41, 3'd1, 1'b0, 1'b0);
    cyc(C_IDLE, 8'h00, 8'h42, 3'd1, 1'b0, 1'b0);
    cyc(C_RET,  8'h00, 8'h11, 3'd0, 1'b0, 1'b0);

    // Conditional jump both ways, then wrap at 0xFF.
    cyc(C_CJ | C_DJ, 8'h20, 8'h12, 3'd0, 1'b0, 1'b0);
    cyc(C_CJ,        8'h20, 8'h20, 3'd0, 1'b0, 1'b0);
    cyc(C_JMP,       8'hFF, 8'hFF, 3'd0, 1'b0, 1'b0);
    cyc(C_IDLE,      8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

    // Nested calls to overflow, LIFO returns, then underflow.
    cyc(C_CALL, 8'h30, 8'h30, 3'd1, 1'b0, 1'b0);
    cyc(C_CALL, 8'h50, 8'h50, 3'd2, 1'b0, 1'b0);
    cyc(C_CALL, 8'h70, 8'h70, 3'd3, 1'b0, 1'b0);
    cyc(C_CALL, 8'h90, 8'h90, 3'd4, 1'b0, 1'b0);
    cyc(C_CALL, 8'hA0, 8'hA0, 3'd4, 1'b1, 1'b0);
    cyc(C_RET,  8'h00, 8'h71, 3'd3, 1'b1, 1'b0);
    cyc(C_RET,  8'h00, 8'h51, 3'd2, 1'b1, 1'b0);
    cyc(C_RET,  8'h00, 8'h31, 3'd1, 1'b1, 1'b0);
    cyc(C_RET,  8'h00, 8'h01, 3'd0, 1'b1, 1'b0);
    cyc(C_RET,  8'h00, 8'h02, 3'd0, 1'b1, 1'b1);

    // call+ret together pops only; stall freezes a pending call.
    cyc(C_CALL,         8'h60, 8'h60, 3'd1, 1'b1, 1'b1);
    cyc(C_CALL | C_RET, 8'h80, 8'h03, 3'd0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(C_STALL | C_CALL, 8'h90, 8'h03, 3'd0, 1'b1, 1'b1);
    cyc(C_CALL,          8'h90, 8'h90, 3'd1, 1'b1, 1'b1);
    cyc(C_STALL | C_RET, 8'h00, 8'h90, 3'd1, 1'b1, 1'b1);

    // Reset mid-operation with sp=3 and flags set.
    cyc(C_CALL, 8'hB0, 8'hB0, 3'd2, 1'b1, 1'b1);
    cyc(C_CALL, 8'hC0, 8'hC0, 3'd3, 1'b1, 1'b1);
    cyc(C_RST | C_STALL | C_CALL | C_RET, 8'h55, 8'h00, 3'd0, 1'b0, 1'b0);
    cyc(C_IDLE, 8'h00, 8'h01, 3'd0, 1'b0, 1'b0);
    cyc(C_RET,  8'h00, 8'h02, 3'd0, 1'b0, 1'b1);
    cyc(C_IDLE, 8'h00, 8'h03, 3'd0, 1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #3;
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
